// File: rtl/alu_sequencer.sv
// Multi-cycle controller for 8080 register/immediate ALU instructions.
// Owns the accumulator and flag byte and drives the shared 8-bit ALU.
module alu_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter logic [7:0]  ACC_RESET   = 8'h00,
  parameter logic [7:0]  FLAG_RESET  = 8'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  input  logic [7:0] op_code,
  output logic       op_ready,
  input  logic       acc_wr,
  input  logic [7:0] acc_wdata,
  output logic [2:0] rf_raddr,
  input  logic [7:0] rf_rdata,
  output logic       mem_req,
  output logic       mem_imm,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  output logic [7:0] alu_opra,
  output logic [7:0] alu_oprb,
  output logic       alu_cin,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_res,
  input  logic       alu_cout,
  input  logic       alu_zout,
  input  logic       alu_sout,
  input  logic       alu_parity,
  input  logic       alu_auxcar,
  output logic [7:0] acc,
  output logic [7:0] flags,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RDREG = 3'd1,
    MEMRD = 3'd2,
    EXEC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] TMO_LAST   = 8'(MEM_TIMEOUT - 1);
  // Bits 5 and 3 are hard zero and bit 1 hard one, whatever the parameter says.
  localparam logic [7:0] FLAG_INIT  = (FLAG_RESET & 8'hD7) | 8'h02;

  state_t     state_reg, state_next;
  logic [7:0] acc_reg, acc_next;
  logic [7:0] flags_reg, flags_next;
  logic [7:0] opcode_reg, opcode_next;
  logic [7:0] operand_reg, operand_next;
  logic [7:0] count_reg, count_next;
  logic       err_reg, err_next;

  logic       op_is_reg;
  logic       op_is_mem;

  assign op_is_reg = (op_code[7:6] == 2'b10) && (op_code[2:0] != 3'b110);
  assign op_is_mem = op_code[7] && (op_code[2:0] == 3'b110);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      acc_reg     <= ACC_RESET;
      flags_reg   <= FLAG_INIT;
      opcode_reg  <= 8'h00;
      operand_reg <= 8'h00;
      count_reg   <= 8'h00;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      flags_reg   <= flags_next;
      opcode_reg  <= opcode_next;
      operand_reg <= operand_next;
      count_reg   <= count_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    flags_next   = flags_reg;
    opcode_next  = opcode_reg;
    operand_next = operand_reg;
    count_next   = count_reg;
    err_next     = err_reg;

    case (state_reg)
      IDLE: begin
        if (acc_wr) begin
          acc_next = acc_wdata;
        end
        if (op_valid) begin
          opcode_next = op_code;
          count_next  = 8'h00;
          err_next    = 1'b0;
          if (op_is_reg) begin
            state_next = RDREG;
          end else if (op_is_mem) begin
            state_next = MEMRD;
          end else begin
            err_next   = 1'b1;
            state_next = DONE;
          end
        end
      end

      RDREG: begin
        // sss=111 names the accumulator itself, which lives here, not in the register file.
        operand_next = (opcode_reg[2:0] == 3'b111) ? acc_reg : rf_rdata;
        state_next   = EXEC;
      end

      MEMRD: begin
        if (mem_ack) begin
          operand_next = mem_data;
          state_next   = EXEC;
        end else if (count_reg == TMO_LAST) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          count_next = count_reg + 8'h01;
        end
      end

      EXEC: begin
        flags_next = {alu_sout, alu_zout, 1'b0, alu_auxcar, 1'b0, alu_parity, 1'b1, alu_cout};
        if (opcode_reg[5:3] != 3'b111) begin
          acc_next = alu_res;
        end
        state_next = DONE;
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign op_ready = (state_reg == IDLE);
  assign mem_req  = (state_reg == MEMRD);
  assign mem_imm  = opcode_reg[6];
  assign rf_raddr = opcode_reg[2:0];
  assign done     = (state_reg == DONE);
  assign err      = (state_reg == DONE) && err_reg;

  assign alu_opra = acc_reg;
  assign alu_oprb = operand_reg;
  assign alu_cin  = flags_reg[0];
  assign alu_sel  = opcode_reg[5:3];

  assign acc      = acc_reg;
  assign flags    = flags_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed cases then random instructions
// checked against an instruction-level model of accumulator, flags and latency.
`timescale 1ns/1ps
module tb_alu_sequencer;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic [7:0] op_code;
  logic       op_ready;
  logic       acc_wr;
  logic [7:0] acc_wdata;
  logic [2:0] rf_raddr;
  logic [7:0] rf_rdata;
  logic       mem_req;
  logic       mem_imm;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic [7:0] alu_opra;
  logic [7:0] alu_oprb;
  logic       alu_cin;
  logic [2:0] alu_sel;
  logic [7:0] alu_res;
  logic       alu_cout;
  logic       alu_zout;
  logic       alu_sout;
  logic       alu_parity;
  logic       alu_auxcar;
  logic [7:0] acc;
  logic [7:0] flags;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  alu_sequencer #(
    .MEM_TIMEOUT(TMO),
    .ACC_RESET  (8'h00),
    .FLAG_RESET (8'h02)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .op_ready  (op_ready),
    .acc_wr    (acc_wr),
    .acc_wdata (acc_wdata),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .mem_req   (mem_req),
    .mem_imm   (mem_imm),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .alu_opra  (alu_opra),
    .alu_oprb  (alu_oprb),
    .alu_cin   (alu_cin),
    .alu_sel   (alu_sel),
    .alu_res   (alu_res),
    .alu_cout  (alu_cout),
    .alu_zout  (alu_zout),
    .alu_sout  (alu_sout),
    .alu_parity(alu_parity),
    .alu_auxcar(alu_auxcar),
    .acc       (acc),
    .flags     (flags),
    .done      (done),
    .err       (err)
  );

  // 8080 ALU semantics: returns {aux_carry, carry, result}; subtract flags are borrows.
  function automatic logic [9:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    int s;
    int h;
    int c;
    c = (op == 3'd1 || op == 3'd3) ? int'(cin) : 0;
    case (op)
      3'd0, 3'd1: begin
        s = int'(a) + int'(b) + c;
        h = int'(a[3:0]) + int'(b[3:0]) + c;
        return {h > 15, s > 255, 8'(s)};
      end
      3'd2, 3'd3, 3'd7: begin
        s = int'(a) - int'(b) - c;
        h = int'(a[3:0]) - int'(b[3:0]) - c;
        return {h < 0, s < 0, 8'(s)};
      end
      3'd4:    return {2'b00, a & b};
      3'd5:    return {2'b00, a ^ b};
      default: return {2'b00, a | b};
    endcase
  endfunction

  logic [7:0] rf [8];
  assign rf_rdata = rf[rf_raddr];

  assign {alu_auxcar, alu_cout, alu_res} = alu_fn(alu_sel, alu_opra, alu_oprb, alu_cin);
  assign alu_zout   = (alu_res == 8'h00);
  assign alu_sout   = alu_res[7];
  assign alu_parity = ~^alu_res;

  typedef struct packed {
    logic [7:0]  acc;
    logic [7:0]  flags;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  logic [7:0]  m_acc;
  logic [7:0]  m_flags;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse retires the oldest expected instruction.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no pending instruction (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("acc", acc, e.acc);
        chk("flags", flags, e.flags);
        chk("err", err, e.err);
        chk("done_cycle", cyc, e.cyc);
        $display("done: acc=%02h flags=%02h err=%0b cyc=%0d", acc, flags, err, cyc);
      end
    end
  end

  task automatic load_acc(input logic [7:0] v);
    acc_wr    = 1'b1;
    acc_wdata = v;
    @(posedge clk); #1;
    acc_wr    = 1'b0;
    m_acc     = v;
  endtask

  // Called #1 after a rising edge with the DUT idle; returns the same way.
  task automatic issue(input logic [7:0] opc, input int ack_wait, input logic [7:0] mdata,
                       input bit wr, input logic [7:0] wdata);
    bit         is_mem;
    bit         legal;
    bit         tmo;
    int         lat;
    logic [7:0] opnd;
    logic [9:0] r;
    exp_t       e;
    op_valid  = 1'b1;
    op_code   = opc;
    acc_wr    = wr;
    acc_wdata = wdata;
    @(negedge clk);
    chk("op_ready", op_ready, 1);
    if (wr) m_acc = wdata;
    is_mem = opc[7] && (opc[2:0] == 3'b110);
    legal  = (opc[7:6] == 2'b10) || is_mem;
    tmo    = is_mem && (ack_wait < 0 || ack_wait >= TMO);
    if (!legal)   lat = 1;
    else if (tmo) lat = 1 + TMO;
    else          lat = 3 + (is_mem ? ack_wait : 0);
    if (legal && !tmo) begin
      opnd = is_mem ? mdata : ((opc[2:0] == 3'b111) ? m_acc : rf[opc[2:0]]);
      r = alu_fn(opc[5:3], m_acc, opnd, m_flags[0]);
      m_flags = {r[7], r[7:0] == 8'h00, 1'b0, r[9], 1'b0, ~^r[7:0], 1'b1, r[8]};
      if (opc[5:3] != 3'b111) m_acc = r[7:0];
    end
    e.acc   = m_acc;
    e.flags = m_flags;
    e.err   = !legal || tmo;
    e.cyc   = cyc + lat;
    sb.push_back(e);
    $display("issue: op=%02h wr=%0b ack_wait=%0d mdata=%02h -> acc=%02h flags=%02h err=%0b",
             opc, wr, ack_wait, mdata, e.acc, e.flags, e.err);
    @(posedge clk); #1;
    op_valid = 1'b0;
    acc_wr   = 1'b0;
    op_code  = 8'($urandom);
    if (legal && is_mem) begin
      for (int j = 0; j < TMO; j++) begin
        mem_ack  = (j == ack_wait);
        mem_data = (j == ack_wait) ? mdata : 8'($urandom);
        @(negedge clk);
        chk("mem_req", mem_req, 1);
        chk("mem_imm", mem_imm, opc[6]);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (j == ack_wait) break;
      end
      if (tmo) begin
        @(negedge clk);
        chk("mem_req_drop", mem_req, 0);
        @(posedge clk); #1;
      end
    end
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    chk("done_seen", sb.size(), 0);
    sb.delete();
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    op_valid  = 1'b0;
    op_code   = 8'h00;
    acc_wr    = 1'b0;
    acc_wdata = 8'h00;
    mem_ack   = 1'b0;
    mem_data  = 8'h00;
    for (int r = 0; r < 8; r++) rf[r] = 8'h00;
    m_acc   = 8'h00;
    m_flags = 8'h02;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_acc", acc, 8'h00);
    chk("rst_flags", flags, 8'h02);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_req", mem_req, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ADD B
    rf[0] = 8'hC6;
    load_acc(8'h3A);
    issue(8'h80, 0, 8'h00, 1'b0, 8'h00);
    chk("add_acc", acc, 8'h00);
    chk("add_flags", flags, 8'h57);

    // SUI with ack two cycles into the request
    load_acc(8'h00);
    issue(8'hD6, 2, 8'h01, 1'b0, 8'h00);
    chk("sui_acc", acc, 8'hFF);
    chk("sui_flags", flags, 8'h97);

    // ADC E with CY left set by SUI
    rf[3] = 8'h00;
    load_acc(8'h0F);
    issue(8'h8B, 0, 8'h00, 1'b0, 8'h00);
    chk("adc_acc", acc, 8'h10);
    chk("adc_flags", flags, 8'h12);

    // CMP C leaves acc alone
    rf[1] = 8'h42;
    load_acc(8'h42);
    issue(8'hB9, 0, 8'h00, 1'b0, 8'h00);
    chk("cmp_acc", acc, 8'h42);
    chk("cmp_flags", flags, 8'h46);

    // ADD M with no ack: timeout leaves state untouched
    issue(8'h86, -1, 8'h00, 1'b0, 8'h00);
    chk("tmo_acc", acc, 8'h42);
    chk("tmo_flags", flags, 8'h46);

    // illegal opcode (HLT)
    issue(8'h76, 0, 8'h00, 1'b0, 8'h00);

    // ack in the last allowed cycle still succeeds
    issue(8'h86, TMO - 1, 8'h11, 1'b0, 8'h00);

    // accumulator load coinciding with accept feeds ADD A
    issue(8'h87, 0, 8'h00, 1'b1, 8'h21);
    chk("wr_add_acc", acc, 8'h42);

    for (int i = 0; i < 300; i++) begin
      logic [7:0] opc;
      int         sel;
      for (int r = 0; r < 8; r++) rf[r] = 8'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      opc = 8'h80 | 8'($urandom_range(0, 63));
      else if (sel < 9) opc = {2'b11, 3'($urandom_range(0, 7)), 3'b110};
      else              opc = 8'($urandom);
      if ($urandom_range(0, 3) == 0) load_acc(8'($urandom));
      issue(opc, int'($urandom_range(0, TMO + 1)), 8'($urandom),
            $urandom_range(0, 3) == 0, 8'($urandom));
    end

    // reset in the middle of a memory read: no done, mem_req drops at once
    load_acc(8'h5C);
    op_valid = 1'b1;
    op_code  = 8'h86;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    chk("mid_mem_req", mem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_acc", acc, 8'h00);
    chk("mid_rst_flags", flags, 8'h02);
    chk("mid_rst_done", done, 0);
    @(posedge clk); #1;
    reset   = 1'b0;
    m_acc   = 8'h00;
    m_flags = 8'h02;
    repeat (6) @(posedge clk);
    #1;

    rf[2] = 8'h7F;
    issue(8'h82, 0, 8'h00, 1'b1, 8'h01);
    chk("post_rst_acc", acc, 8'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
